vga_fb_arbiter: RTL
===================

// Module: vga_fb_arbiter
// PURPOSE
//  Shares one single-port frame-buffer BRAM between the VGA display path and two writers: a bulk clear engine and a pixel writer (pen/Sudoku drawing).
//  Sits between the VGA timing generator and the BRAM. Turns h_cnt/v_cnt/valid into 4x-downsampled FB reads and outputs aligned RGB and syncs.
//  Writes use only the cycles the display does not need.
// PARAMETERS
//  FB_W        160     frame-buffer width in pixels (640 >> SCALE_SHIFT)
//  FB_H        120     frame-buffer height in pixels (480 >> SCALE_SHIFT)
//  SCALE_SHIFT 2       screen-to-FB downscale shift (fixed 4x4 replication)
//  AW          15      FB address width (FB_W*FB_H = 19200 must fit)
//  DW          12      pixel width, RGB444
//  CLR_COLOR   12'h000 value written by the clear engine
// PORTS
//  pclk      in   1   pixel clock
//  reset     in   1   synchronous, active-high
//  h_cnt     in   10  screen column, 0 when not valid
//  v_cnt     in   10  screen row, 0 when not valid
//  valid     in   1   active video
//  hsync_in  in   1   hsync from timing generator
//  vsync_in  in   1   vsync from timing generator
//  hsync     out  1   hsync_in delayed 3 cycles
//  vsync     out  1   vsync_in delayed 3 cycles
//  rgb       out  DW  pixel colour, aligned with hsync/vsync, 0 outside active video
//  wr_req    in   1   pixel-write request; wr_addr and wr_data held stable until wr_ack
//  wr_addr   in   AW  linear FB address
//  wr_data   in   DW  pixel value
//  wr_ack    out  1   1-cycle pulse: request consumed
//  clr_start in   1   1-cycle pulse: start a full-FB clear
//  clr_busy  out  1   clear in progress
//  fb_addr   out  AW  BRAM address (registered)
//  fb_we     out  1   BRAM write enable (registered)
//  fb_wdata  out  DW  BRAM write data (registered)
//  fb_rdata  in   DW  BRAM read data, valid the cycle after fb_addr
// BEHAVIOUR
//  Reset: hsync=vsync=1, rgb=0, fb_addr=0, fb_we=0, fb_wdata=0, wr_ack=0, clr_busy=0.
//    Clear counter=0, FSM=IDLE, delay pipes cleared.
//  Display read slot at sample cycle t: disp_rd = valid && h_cnt[1:0]==0.
//    Address = (v_cnt>>2)*FB_W + (h_cnt>>2), computed as r*128 + r*32 + c (no multiplier).
//  Timing: fb_addr at t+1, fb_rdata at t+2, captured into rgb at t+3.
//    rgb holds that value for the next 3 pixels (4x horizontal replication).
//    valid is piped 3 cycles; when the piped valid is 0, rgb=0.
//  Priority per cycle: display read > clear write > pixel write. Writers may use only non-display-read cycles.
//  Clear FSM: IDLE->CLEAR on clr_start (clr_busy=1 from the next cycle).
//    In CLEAR, each free slot writes CLR_COLOR at clr_cnt, then clr_cnt increments.
//    After the write to FB_W*FB_H-1: go to IDLE, clr_busy=0, clr_cnt=0.
//    clr_start while already in CLEAR is ignored (no restart).
//  Pixel write: granted only when the FSM is IDLE (clr_busy=0) and the slot is free.
//    fb_we=1 with wr_addr/wr_data, and wr_ack=1 in the same registered cycle.
//    wr_addr >= FB_W*FB_H: wr_ack pulses, fb_we stays 0 (request dropped).
//    Requester deasserts wr_req the cycle after wr_ack. If wr_req is still high, it is a new request,
//      eligible no earlier than 1 cycle after the ack.
//  Idle cycle (no read, no write): fb_we=0, fb_addr holds its previous value.
//  Blanking (valid=0): every cycle is a free slot. Active video gives 3 of 4 free cycles, so a full clear takes <1 frame.
//  Reset mid-clear: clear aborts, clr_busy=0, FB contents partially cleared (no error flag).
// STRUCTURE
//  Package vga_fb_pkg: FB_W, FB_H, FB_SIZE, SCALE_SHIFT, AW, DW, PIPE_LAT=3, FSM state encoding {IDLE, CLEAR}.
//  Sub-module vga_fb_addr_gen: registered (h_cnt,v_cnt)->linear address, shift-add, 1-cycle latency.
//  Top level: slot decode, clear FSM and counter, write mux, rdata capture, 3-deep valid/hsync/vsync delay.
// TESTING
//  1 Reset with all inputs toggling -> all outputs at reset values, wr_ack never pulses while reset=1.
//  2 valid=1, v_cnt=4, h_cnt=8 at t -> fb_addr=162 at t+1, rgb=BRAM[162] at t+3..t+6, hsync/vsync = inputs delayed 3.
//  3 wr_req (addr 5, data 12'hF00) at h_cnt=4 (read slot) -> no write at that slot. Write+ack at the h_cnt=5 slot. BRAM[5]=F00.
//  4 clr_start during active video, then wr_req mid-clear -> exactly 19200 CLR_COLOR writes, no wr_ack until clr_busy=0, then write+ack.
//  5 wr_req with wr_addr=19200 -> wr_ack pulse, fb_we stays 0, BRAM unchanged.
//  6 reset asserted after 1000 clear writes -> clr_busy=0 next cycle. New clr_start restarts from address 0.

Source files
------------

// File: rtl/vga_fb_pkg.sv
`default_nettype none
// ============================================================================
//  Package : vga_fb_pkg
//  Shared constants and types for the VGA frame-buffer arbiter: frame-buffer
//  geometry, bus widths, display pipeline latency and the clear-FSM encoding.
//  Revision: 1.0  initial release
// ============================================================================
package vga_fb_pkg;

    localparam int FB_W        = 160;          // 640 >> SCALE_SHIFT
    localparam int FB_H        = 120;          // 480 >> SCALE_SHIFT
    localparam int FB_SIZE     = FB_W * FB_H;  // 19200 pixels
    localparam int SCALE_SHIFT = 2;            // fixed 4x4 pixel replication
    localparam int AW          = 15;           // FB address width
    localparam int DW          = 12;           // RGB444 pixel width
    localparam int PIPE_LAT    = 3;            // h/v sample -> rgb/sync output

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

endpackage
`default_nettype wire

// File: rtl/vga_fb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Interface : vga_fb_arbiter_if
//  Pixel-writer request/acknowledge handshake.
//    wr_req  : request, address/data held stable until wr_ack
//    wr_addr : linear frame-buffer address
//    wr_data : pixel value
//    wr_ack  : one-cycle pulse when the request has been consumed
//  master = pixel writer, slave = arbiter.
//  Revision: 1.0  initial release
// ============================================================================
interface vga_fb_arbiter_if;
    import vga_fb_pkg::*;

    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ack;

    modport master (output wr_req, output wr_addr, output wr_data, input  wr_ack);
    modport slave  (input  wr_req, input  wr_addr, input  wr_data, output wr_ack);

endinterface
`default_nettype wire

// File: rtl/vga_fb_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module : vga_fb_addr_gen
//  Owns the frame-buffer address register. On a display-read slot it loads the
//  linear address of the downscaled pixel (row*160 + col, built as
//  row*128 + row*32 + col); on a write slot it loads the writer address;
//  otherwise it holds. One cycle of latency.
//  Ports: pclk, reset, h_cnt/v_cnt (screen position), disp_rd, wr_en,
//         wr_addr (writer address), fb_addr (registered BRAM address).
//  Revision: 1.0  initial release
// ============================================================================
module vga_fb_addr_gen
    import vga_fb_pkg::*;
(
    input  wire          pclk,
    input  wire          reset,
    input  wire [9:0]    h_cnt,
    input  wire [9:0]    v_cnt,
    input  wire          disp_rd,
    input  wire          wr_en,
    input  wire [AW-1:0] wr_addr,
    output logic [AW-1:0] fb_addr
);

    logic [6:0]    w_row;        // 0..119
    logic [7:0]    w_col;        // 0..159
    logic [AW-1:0] w_disp_addr;
    logic          w_unused;

    assign w_row = v_cnt[SCALE_SHIFT +: 7];
    assign w_col = h_cnt[SCALE_SHIFT +: 8];

    // FB_W = 160 = 128 + 32, so the row multiply is two shifted copies.
    assign w_disp_addr = {1'b0, w_row, 7'b0} + {3'b0, w_row, 5'b0} + {7'b0, w_col};

    // Low bits select the sub-pixel within a 4x4 block; v_cnt never exceeds 479.
    assign w_unused = ^{v_cnt[9], v_cnt[1:0], h_cnt[1:0]};

    always_ff @(posedge pclk) begin
        if (reset) begin
            fb_addr <= '0;
        end else if (disp_rd) begin
            fb_addr <= w_disp_addr;
        end else if (wr_en) begin
            fb_addr <= wr_addr;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module : vga_fb_arbiter
//  Shares a single-port frame-buffer BRAM between the VGA display path, a
//  bulk clear engine and a pixel writer. Display reads take every 4th pixel
//  of active video; the clear engine and then the pixel writer use the rest.
//  Ports: pclk/reset; h_cnt, v_cnt, valid, hsync_in, vsync_in from the timing
//         generator; hsync, vsync, rgb to the DAC (3-cycle aligned);
//         wr_bus (pixel-write handshake); clr_start/clr_busy (clear engine);
//         fb_addr, fb_we, fb_wdata, fb_rdata (BRAM port).
//  Revision: 1.0  initial release
// ============================================================================
module vga_fb_arbiter
    import vga_fb_pkg::*;
#(
    parameter logic [DW-1:0] CLR_COLOR = 12'h000
)
(
    input  wire           pclk,
    input  wire           reset,
    input  wire  [9:0]    h_cnt,
    input  wire  [9:0]    v_cnt,
    input  wire           valid,
    input  wire           hsync_in,
    input  wire           vsync_in,
    output logic          hsync,
    output logic          vsync,
    output logic [DW-1:0] rgb,
    vga_fb_arbiter_if.slave wr_bus,
    input  wire           clr_start,
    output logic          clr_busy,
    output logic [AW-1:0] fb_addr,
    output logic          fb_we,
    output logic [DW-1:0] fb_wdata,
    input  wire  [DW-1:0] fb_rdata
);

    localparam logic [AW-1:0] c_fb_last = AW'(FB_SIZE - 1);

    clr_state_t    r_state;
    logic [AW-1:0] r_clr_cnt;
    logic          r_wr_ack;
    logic [1:0]    r_valid_d;
    logic [1:0]    r_rd_d;
    logic [PIPE_LAT-1:0] r_hs_d;
    logic [PIPE_LAT-1:0] r_vs_d;

    logic          w_disp_rd;
    logic          w_clr_wr;
    logic          w_pix_slot;
    logic          w_pix_wr;
    logic          w_wr_en;
    logic [AW-1:0] w_wr_addr;

    // ---------------- slot decode and priority ----------------
    assign w_disp_rd = valid && (h_cnt[1:0] == 2'b00);
    assign w_clr_wr  = (r_state == CLEAR) && !w_disp_rd;
    // r_wr_ack blocks the cycle in which the ack is visible, so a wr_req still
    // high there is treated as a fresh request one cycle later.
    assign w_pix_slot = (r_state == IDLE) && !w_disp_rd && wr_bus.wr_req && !r_wr_ack;
    // Out-of-range requests are acknowledged but never reach the BRAM.
    assign w_pix_wr  = w_pix_slot && (wr_bus.wr_addr <= c_fb_last);
    assign w_wr_en   = w_clr_wr || w_pix_wr;
    assign w_wr_addr = w_clr_wr ? r_clr_cnt : wr_bus.wr_addr;

    vga_fb_addr_gen u_addr_gen (
        .pclk    (pclk),
        .reset   (reset),
        .h_cnt   (h_cnt),
        .v_cnt   (v_cnt),
        .disp_rd (w_disp_rd),
        .wr_en   (w_wr_en),
        .wr_addr (w_wr_addr),
        .fb_addr (fb_addr)
    );

    // ---------------- clear FSM ----------------
    always_ff @(posedge pclk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_clr_cnt <= '0;
            clr_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (clr_start) begin
                        r_state  <= CLEAR;
                        clr_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (w_clr_wr) begin
                        if (r_clr_cnt == c_fb_last) begin
                            r_state   <= IDLE;
                            clr_busy  <= 1'b0;
                            r_clr_cnt <= '0;
                        end else begin
                            r_clr_cnt <= r_clr_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    clr_busy <= 1'b0;
                end
            endcase
        end
    end

    // ---------------- BRAM write port and ack ----------------
    always_ff @(posedge pclk) begin
        if (reset) begin
            fb_we    <= 1'b0;
            fb_wdata <= '0;
            r_wr_ack <= 1'b0;
        end else begin
            fb_we    <= w_wr_en;
            r_wr_ack <= w_pix_slot;
            if (w_wr_en) begin
                fb_wdata <= w_clr_wr ? CLR_COLOR : wr_bus.wr_data;
            end
        end
    end

    assign wr_bus.wr_ack = r_wr_ack;

    // ---------------- display pipeline ----------------
    // Read issued at t, address at t+1, data at t+2, rgb at t+3; rgb is held
    // between reads, which gives the 4x horizontal replication.
    always_ff @(posedge pclk) begin
        if (reset) begin
            r_valid_d <= '0;
            r_rd_d    <= '0;
            r_hs_d    <= '1;
            r_vs_d    <= '1;
            rgb       <= '0;
        end else begin
            r_valid_d <= {r_valid_d[0], valid};
            r_rd_d    <= {r_rd_d[0], w_disp_rd};
            r_hs_d    <= {r_hs_d[PIPE_LAT-2:0], hsync_in};
            r_vs_d    <= {r_vs_d[PIPE_LAT-2:0], vsync_in};
            if (!r_valid_d[1]) begin
                rgb <= '0;
            end else if (r_rd_d[1]) begin
                rgb <= fb_rdata;
            end
        end
    end

    assign hsync = r_hs_d[PIPE_LAT-1];
    assign vsync = r_vs_d[PIPE_LAT-1];

endmodule
`default_nettype wire
